calc_ctrl: RTL

//  Sequencing FSM for the calculator.
//  - Collects operand A, the operation and operand B from the board switches and keys.
//  - Starts the ALU with a one-cycle pulse, then waits for it to finish.
//  - Drives the data/control pair consumed by the 7-segment driver (contr 0/1/2/4 codes).
//  - Sits between the board I/O and the ALU/segment blocks and replaces ad-hoc arifs muxing.

---
 rtl/calc_ctrl_if.sv | 27 ++
 rtl/calc_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_ctrl_if.sv
// Signal bundle between the calculator sequencer and the board I/O, ALU and 7-segment driver.
// The sequencer takes the master side; the board/ALU environment takes the slave side.
interface calc_ctrl_if;
    logic [3:0]  sw;
    logic [1:0]  keys;
    logic [3:0]  arifs;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [1:0]  alu_op;
    logic        alu_start;
    logic        alu_done;
    logic [10:0] alu_res;
    logic [2:0]  alu_c;
    logic [10:0] disp_data;
    logic [2:0]  disp_contr;
    logic        busy;

    modport master (
        input  sw, keys, arifs, alu_done, alu_res, alu_c,
        output alu_a, alu_b, alu_op, alu_start, disp_data, disp_contr, busy
    );

    modport slave (
        output sw, keys, arifs, alu_done, alu_res, alu_c,
        input  alu_a, alu_b, alu_op, alu_start, disp_data, disp_contr, busy
    );
endinterface

// File: rtl/calc_ctrl.sv
// Calculator sequencer: debounces keys and op buttons, collects A/op/B, kicks the ALU,
// waits for its result (with timeout) and drives the 7-segment data/control pair.
module calc_ctrl #(
    parameter int DEB_CNT = 50000,
    parameter int TO_CNT  = 1024
) (
    input  logic        Clk,
    input  logic        Rst,
    calc_ctrl_if.master io
);
    localparam int NIN   = 6;
    localparam int DEB_W = $clog2(DEB_CNT + 1);
    localparam int TO_W  = $clog2(TO_CNT + 1);

    typedef enum logic [2:0] {
        ST_GET_A  = 3'd0,
        ST_GET_OP = 3'd1,
        ST_GET_B  = 3'd2,
        ST_START  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_SHOW   = 3'd5
    } state_t;

    logic [NIN-1:0]   raw;
    logic [NIN-1:0]   sync1_q;
    logic [NIN-1:0]   sync2_q;
    logic [NIN-1:0]   stable_q;
    logic [NIN-1:0]   stable_d;
    logic [NIN-1:0]   press_q;
    logic [NIN-1:0]   press_d;
    logic [DEB_W-1:0] deb_cnt_q [NIN];
    logic [DEB_W-1:0] deb_cnt_d [NIN];

    logic             enter_ev;
    logic             clear_ev;
    logic [3:0]       op_press;
    logic             op_ev;
    logic [1:0]       op_code;

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       alu_a_q;
    logic [3:0]       alu_a_d;
    logic [3:0]       alu_b_q;
    logic [3:0]       alu_b_d;
    logic [1:0]       alu_op_q;
    logic [1:0]       alu_op_d;
    logic             alu_start_q;
    logic             alu_start_d;
    logic             busy_q;
    logic             busy_d;
    logic [10:0]      disp_data_q;
    logic [10:0]      disp_data_d;
    logic [2:0]       disp_contr_q;
    logic [2:0]       disp_contr_d;
    logic [TO_W-1:0]  to_cnt_q;
    logic [TO_W-1:0]  to_cnt_d;
    logic [TO_W-1:0]  to_next;

    // Bits [1:0] are enter/clear, bits [5:2] are add/sub/mul/div; all active-low.
    assign raw = {io.arifs, io.keys};

    // A synced level that disagrees with the stable level for DEB_CNT cycles in a row wins;
    // any agreeing sample in between restarts the count.
    always_comb begin
        stable_d = stable_q;
        press_d  = '0;
        for (int i = 0; i < NIN; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (deb_cnt_q[i] == DEB_W'(DEB_CNT - 1)) begin
                    stable_d[i] = sync2_q[i];
                    press_d[i]  = ~sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            stable_q <= '1;
            press_q  <= '0;
            for (int i = 0; i < NIN; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            for (int i = 0; i < NIN; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    assign enter_ev = press_q[0];
    assign clear_ev = press_q[1];
    assign op_press = press_q[5:2];
    assign op_ev    = $onehot(op_press);
    assign to_next  = to_cnt_q + TO_W'(1);

    always_comb begin
        op_code = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (op_press[i]) begin
                op_code = 2'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        disp_data_d  = disp_data_q;
        disp_contr_d = disp_contr_q;
        to_cnt_d     = to_cnt_q;

        // Clear overrides everything, including a result landing in the same cycle.
        if (clear_ev) begin
            state_d      = ST_GET_A;
            alu_a_d      = 4'd0;
            alu_b_d      = 4'd0;
            alu_op_d     = 2'd0;
            disp_data_d  = {7'b0, io.sw};
            disp_contr_d = 3'd0;
        end else begin
            case (state_q)
                ST_GET_A: begin
                    disp_data_d  = {7'b0, io.sw};
                    disp_contr_d = 3'd0;
                    if (enter_ev) begin
                        alu_a_d = io.sw;
                        state_d = ST_GET_OP;
                    end
                end
                ST_GET_OP: begin
                    disp_data_d  = {7'b0, alu_a_q};
                    disp_contr_d = 3'd0;
                    if (op_ev) begin
                        alu_op_d = op_code;
                        state_d  = ST_GET_B;
                    end
                end
                ST_GET_B: begin
                    disp_data_d  = {7'b0, io.sw};
                    disp_contr_d = 3'd0;
                    if (enter_ev) begin
                        alu_b_d = io.sw;
                        state_d = ST_START;
                    end
                end
                ST_START: begin
                    to_cnt_d = '0;
                    state_d  = ST_WAIT;
                end
                ST_WAIT: begin
                    if (io.alu_done) begin
                        disp_data_d  = io.alu_res;
                        disp_contr_d = io.alu_c;
                        state_d      = ST_SHOW;
                    end else if (to_next == TO_W'(TO_CNT - 1)) begin
                        disp_data_d  = 11'd0;
                        disp_contr_d = 3'd2;
                        state_d      = ST_SHOW;
                    end else begin
                        to_cnt_d = to_next;
                    end
                end
                ST_SHOW: begin
                    if (enter_ev) begin
                        state_d = ST_GET_A;
                    end
                end
                default: begin
                    state_d = ST_GET_A;
                end
            endcase
        end

        // Decoded from the next state so the registered outputs line up with the state register.
        alu_start_d = (state_d == ST_START);
        busy_d      = (state_d == ST_START) || (state_d == ST_WAIT);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= ST_GET_A;
            alu_a_q      <= 4'd0;
            alu_b_q      <= 4'd0;
            alu_op_q     <= 2'd0;
            alu_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            disp_data_q  <= 11'd0;
            disp_contr_q <= 3'd0;
            to_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            alu_start_q  <= alu_start_d;
            busy_q       <= busy_d;
            disp_data_q  <= disp_data_d;
            disp_contr_q <= disp_contr_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

    assign io.alu_a      = alu_a_q;
    assign io.alu_b      = alu_b_q;
    assign io.alu_op     = alu_op_q;
    assign io.alu_start  = alu_start_q;
    assign io.busy       = busy_q;
    assign io.disp_data  = disp_data_q;
    assign io.disp_contr = disp_contr_q;
endmodule
